duty_ramp_generator: RTL

// - Upstream feeder of the PWM signal generator: produces the 16-bit duty word on its comparator input.
// - Moves the duty value from its current level to a requested target in fixed steps.

---
 rtl/duty_ramp_generator_pkg.sv | 13 +
 rtl/duty_ramp_generator_if.sv | 27 ++
 rtl/duty_ramp_generator_period_ticker.sv | 36 +++
 rtl/duty_ramp_generator.sv | 128 ++++++++++++
 4 files changed

// File: rtl/duty_ramp_generator_pkg.sv
// Shared definitions for the duty ramp generator and the PWM signal generator it feeds.
// The period constant must stay in step with the PWM counter terminal count.
package duty_ramp_generator_pkg;

  localparam int unsigned DUTY_W     = 16;
  localparam int unsigned PWM_PERIOD = 24000;

  typedef enum logic [0:0] {
    StIdle,
    StRamp
  } state_e;

endpackage

// File: rtl/duty_ramp_generator_if.sv
// Target request channel of the duty ramp generator: valid/ready plus target duty and step.
interface duty_ramp_generator_if
  import duty_ramp_generator_pkg::*;
#(
  parameter int unsigned WIDTH = DUTY_W
);

  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_duty;
  logic [WIDTH-1:0] tgt_step;

  modport master (
    output tgt_valid,
    output tgt_duty,
    output tgt_step,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_duty,
    input  tgt_step,
    output tgt_ready
  );

endinterface

// File: rtl/duty_ramp_generator_period_ticker.sv
// Free-running PWM period counter; period_tick is high while the count sits at its last value.
module duty_ramp_generator_period_ticker
  import duty_ramp_generator_pkg::*;
#(
  parameter int unsigned PERIOD = PWM_PERIOD
) (
  input  logic CLK,
  input  logic Reset,
  output logic period_tick
);

  localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PERIOD - 1);

  logic [CntW-1:0] pcnt_q, pcnt_d;
  logic            tick_q, tick_d;

  always_comb begin
    pcnt_d = (pcnt_q == LastCnt) ? '0 : pcnt_q + 1'b1;
    // Registered tick: decode the next count so the flag lines up with pcnt == PERIOD-1.
    tick_d = (pcnt_d == LastCnt);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= tick_d;
    end
  end

  assign period_tick = tick_q;

endmodule

// File: rtl/duty_ramp_generator.sv
// Soft-start/soft-stop duty source for the PWM generator: walks duty toward a requested
// target by a fixed step, changing only on PWM period boundaries.
module duty_ramp_generator
  import duty_ramp_generator_pkg::*;
#(
  parameter int unsigned WIDTH    = DUTY_W,
  parameter int unsigned PERIOD   = PWM_PERIOD,
  parameter int unsigned MAX_DUTY = PWM_PERIOD
) (
  input  logic                        CLK,
  input  logic                        Reset,
  duty_ramp_generator_if.slave        tgt,
  input  logic                        estop,
  output logic [WIDTH-1:0]            duty,
  output logic                        busy,
  output logic                        done,
  output logic                        period_tick
);

  localparam logic [WIDTH:0] MaxDutyW = (WIDTH + 1)'(MAX_DUTY);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             transfer;
  logic [WIDTH-1:0] tgt_clamped;
  logic [WIDTH-1:0] step_fixed;
  logic [WIDTH:0]   duty_w, tgt_w, step_w;
  logic [WIDTH:0]   duty_sum;
  logic [WIDTH-1:0] ramp_next;

  duty_ramp_generator_period_ticker #(
    .PERIOD (PERIOD)
  ) u_period_ticker (
    .CLK         (CLK),
    .Reset       (Reset),
    .period_tick (period_tick)
  );

  assign transfer = tgt.tgt_valid & tgt.tgt_ready & ~estop;

  always_comb begin
    tgt_clamped = ({1'b0, tgt.tgt_duty} > MaxDutyW) ? MaxDutyW[WIDTH-1:0] : tgt.tgt_duty;
    step_fixed  = (tgt.tgt_step == '0) ? WIDTH'(1) : tgt.tgt_step;
  end

  // One extra bit of headroom so neither the rise nor the fall can wrap around.
  always_comb begin
    duty_w   = {1'b0, duty_q};
    tgt_w    = {1'b0, tgt_q};
    step_w   = {1'b0, step_q};
    duty_sum = duty_w + step_w;
    if (duty_q < tgt_q) begin
      ramp_next = (duty_sum >= tgt_w) ? tgt_q : duty_sum[WIDTH-1:0];
    end else if (duty_q > tgt_q) begin
      ramp_next = (step_w >= (duty_w - tgt_w)) ? tgt_q : (duty_q - step_q);
    end else begin
      ramp_next = duty_q;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    done_d  = 1'b0;

    if (estop) begin
      state_d = StIdle;
      duty_d  = '0;
      tgt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (transfer) begin
            tgt_d   = tgt_clamped;
            step_d  = step_fixed;
            state_d = StRamp;
          end
        end
        StRamp: begin
          // A target equal to the current duty still waits for one tick before finishing.
          if (period_tick) begin
            duty_d = ramp_next;
            if (ramp_next == tgt_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    ready_d = (state_d == StIdle) & ~estop;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= WIDTH'(1);
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign tgt.tgt_ready = ready_q & ~estop;
  assign duty          = duty_q;
  assign busy          = (state_q == StRamp);
  assign done          = done_q;

endmodule
